csr_access_unit: RTL and testbench

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_access_unit.sv | 142 ++++++++++++++
 tb/tb_csr_access_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// CSR read/set unit: executes CSRRS/CSRRSI against an external CSR file, one
// instruction at a time, and returns the pre-write CSR value for writeback.
module csr_access_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              res,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_funct3,
    input  logic [11:0]       in_csr,
    input  logic [DATA_W-1:0] in_rs1_val,
    input  logic [4:0]        in_uimm,
    input  logic [4:0]        in_rd,
    output logic              csr_request,
    output logic [11:0]       csr_A,
    output logic [DATA_W-1:0] csr_mode,
    input  logic [DATA_W-1:0] csr_Q,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic              illegal,
    output logic              instr_done,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid and its payload stay stable until that edge, ready may change freely.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [11:0]       addr_q, addr_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [4:0]        rd_q, rd_d;
    logic              we_q, we_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;

    logic op_ok;
    logic addr_ok;

    always_comb begin
        op_ok = (in_funct3 == 3'b010) || (in_funct3 == 3'b110);
        case (in_csr)
            12'hC00, 12'hC80, 12'hC01, 12'hC81,
            12'hC02, 12'hC82, 12'hF14: addr_ok = 1'b1;
            default:                   addr_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        rd_d      = rd_q;
        we_d      = we_q;
        illegal_d = illegal_q;
        data_d    = data_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    addr_d = in_csr;
                    rd_d   = in_rd;
                    data_d = '0;
                    if (op_ok && addr_ok) begin
                        mask_d    = in_funct3[2] ? {{(DATA_W-5){1'b0}}, in_uimm} : in_rs1_val;
                        we_d      = (in_rd != 5'd0);
                        illegal_d = 1'b0;
                        state_d   = READ;
                    end else begin
                        mask_d    = '0;
                        we_d      = 1'b0;
                        illegal_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            READ: begin
                // Sample before any write so the result is the pre-OR value.
                data_d  = csr_Q;
                state_d = (mask_q != '0) ? WRITE : RESP;
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (wb_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mask_q    <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            illegal_q <= illegal_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    // All outputs decode directly from flops, so reset clears them immediately.
    assign in_ready    = (state_q == IDLE);
    assign csr_request = (state_q == WRITE);
    assign csr_A       = ((state_q == READ) || (state_q == WRITE)) ? addr_q : 12'd0;
    assign csr_mode    = (state_q == WRITE) ? mask_q : '0;
    assign wb_valid    = (state_q == RESP);
    assign wb_rd       = rd_q;
    assign wb_data     = data_q;
    assign wb_we       = we_q;
    assign illegal     = illegal_q;
    assign instr_done  = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small CSR-file model driving csr_Q.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [11:0] in_csr = '0;
    logic [31:0] in_rs1_val = '0;
    logic [4:0]  in_uimm = '0;
    logic [4:0]  in_rd = '0;
    logic        csr_request;
    logic [11:0] csr_A;
    logic [31:0] csr_mode;
    logic [31:0] csr_Q;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        illegal;
    logic        instr_done;
    logic [1:0]  dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    csr_access_unit #(.DATA_W(32)) dut (
        .clk(clk), .res(res),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_csr(in_csr), .in_rs1_val(in_rs1_val),
        .in_uimm(in_uimm), .in_rd(in_rd),
        .csr_request(csr_request), .csr_A(csr_A), .csr_mode(csr_mode), .csr_Q(csr_Q),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_we(wb_we), .illegal(illegal), .instr_done(instr_done), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR file model: seven CSRs, F14 holds hart id 1; set-requests OR in the mask.
    logic [31:0] csr_mem [7];
    logic        mem_ready = 1'b0;
    logic        req_seen = 1'b0;
    logic [11:0] req_a = '0;
    logic [31:0] req_m = '0;
    int          req_cnt = 0;

    function automatic int csr_idx(input logic [11:0] a);
        case (a)
            12'hC00: return 0;
            12'hC80: return 1;
            12'hC01: return 2;
            12'hC81: return 3;
            12'hC02: return 4;
            12'hC82: return 5;
            12'hF14: return 6;
            default: return 7;
        endcase
    endfunction

    always_comb begin
        csr_Q = '0;
        if (csr_idx(csr_A) < 7) csr_Q = csr_mem[csr_idx(csr_A)];
    end

    always @(posedge clk) begin
        if (!mem_ready) begin
            csr_mem[0] <= 32'h100;
            csr_mem[1] <= 32'h0;
            csr_mem[2] <= 32'h200;
            csr_mem[3] <= 32'h0;
            csr_mem[4] <= 32'h300;
            csr_mem[5] <= 32'h0;
            csr_mem[6] <= 32'h1;
            mem_ready  <= 1'b1;
        end else if (req_seen && res) begin
            if (csr_idx(req_a) < 7) csr_mem[csr_idx(req_a)] <= csr_mem[csr_idx(req_a)] | req_m;
            req_cnt <= req_cnt + 1;
        end
    end

    // Output monitor, sampled just after the falling edge
    int          wbv_cnt = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    always @(negedge clk) begin
        #1;
        req_seen <= csr_request;
        req_a    <= csr_A;
        req_m    <= csr_mode;
        if (wb_valid) wbv_cnt <= wbv_cnt + 1;
        if (wb_valid && wb_ready) begin
            hs_cnt <= hs_cnt + 1;
            got_q.push_back({wb_rd, wb_data});
        end
        if (instr_done) done_cnt <= done_cnt + 1;
    end

    // Driver / checker tasks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                           input logic [4:0] ui, input logic [4:0] rd);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        in_funct3  = f3;
        in_csr     = a;
        in_rs1_val = rs1;
        in_uimm    = ui;
        in_rd      = rd;
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_wb(output int lat);
        int n = 0;
        while (!wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - acc_cyc + 1;
    endtask

    task automatic finish_wb(input string tag);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk({tag, "_done_pulse"}, {31'd0, instr_done}, 32'd1);
        chk({tag, "_wb_valid_low"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk({tag, "_done_single"}, {31'd0, instr_done}, 32'd0);
    endtask

    task automatic chk_wb(input string tag, input int lat, input int exp_lat,
                          input logic [31:0] d, input logic [4:0] rd, input logic we, input logic ill);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_wb_data"}, wb_data, d);
        chk({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
        chk({tag, "_wb_we"}, {31'd0, wb_we}, {31'd0, we});
        chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, ill});
    endtask

    initial begin
        int lat;
        int r0;
        int w0;
        int d0;
        int h0;
        int base;
        int k;
        logic acc;
        logic [36:0] g;
        logic [36:0] e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_csr_request", {31'd0, csr_request}, 32'd0);
        chk("rst_csr_A", {20'd0, csr_A}, 32'd0);
        chk("rst_csr_mode", csr_mode, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_instr_done", {31'd0, instr_done}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        res = 1'b1;

        // CSRRS x5, mhartid, x0: read only
        r0 = req_cnt;
        send_op(3'b010, 12'hF14, 32'd0, 5'd0, 5'd5);
        chk("rs_read_csr_A", {20'd0, csr_A}, 32'h0000_0F14);
        chk("rs_read_no_req", {31'd0, csr_request}, 32'd0);
        wait_wb(lat);
        chk_wb("rs_hartid", lat, 2, 32'd1, 5'd5, 1'b1, 1'b0);
        chk("rs_no_request", req_cnt, r0);
        finish_wb("rs_hartid");

        // CSRRSI x0, mhartid, 6: one-cycle set request, pre-write value returned
        r0 = req_cnt;
        send_op(3'b110, 12'hF14, 32'hFFFF_FFFF, 5'd6, 5'd0);
        chk("rsi_read_mode", csr_mode, 32'd0);
        @(negedge clk);
        chk("rsi_write_req", {31'd0, csr_request}, 32'd1);
        chk("rsi_write_A", {20'd0, csr_A}, 32'h0000_0F14);
        chk("rsi_write_mode", csr_mode, 32'd6);
        wait_wb(lat);
        chk_wb("rsi", lat, 3, 32'd1, 5'd0, 1'b0, 1'b0);
        chk("rsi_one_request", req_cnt, r0 + 1);
        chk("rsi_resp_A", {20'd0, csr_A}, 32'd0);
        finish_wb("rsi");

        send_op(3'b010, 12'hF14, 32'd0, 5'd0, 5'd5);
        wait_wb(lat);
        chk_wb("rs_after_set", lat, 2, 32'd7, 5'd5, 1'b1, 1'b0);
        finish_wb("rs_after_set");

        // Illegal: CSRRW x3, C00 and CSRRS to an unsupported address
        r0 = req_cnt;
        send_op(3'b001, 12'hC00, 32'h0000_00FF, 5'd0, 5'd3);
        wait_wb(lat);
        chk_wb("ill_csrrw", lat, 1, 32'd0, 5'd3, 1'b0, 1'b1);
        finish_wb("ill_csrrw");
        send_op(3'b010, 12'h300, 32'h0000_00FF, 5'd0, 5'd4);
        wait_wb(lat);
        chk_wb("ill_addr", lat, 1, 32'd0, 5'd4, 1'b0, 1'b1);
        finish_wb("ill_addr");
        chk("ill_no_request", req_cnt, r0);

        // Backpressure: wb_ready held low for five cycles
        send_op(3'b010, 12'hC00, 32'd0, 5'd0, 5'd7);
        wait_wb(lat);
        chk_wb("bp", lat, 2, 32'h100, 5'd7, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("bp_wb_data", wb_data, 32'h100);
            chk("bp_wb_rd", {27'd0, wb_rd}, 32'd7);
            chk("bp_wb_we", {31'd0, wb_we}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_instr_done", {31'd0, instr_done}, 32'd0);
        end
        finish_wb("bp");

        // Reset asserted during WRITE aborts the transaction
        send_op(3'b110, 12'hC02, 32'd0, 5'd3, 5'd2);
        @(negedge clk);
        chk("abort_in_write", {31'd0, csr_request}, 32'd1);
        r0 = req_cnt;
        w0 = wbv_cnt;
        d0 = done_cnt;
        #2 res = 1'b0;
        #1;
        chk("abort_req_drop", {31'd0, csr_request}, 32'd0);
        chk("abort_A_zero", {20'd0, csr_A}, 32'd0);
        chk("abort_mode_zero", csr_mode, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        res = 1'b1;
        chk("abort_ready_after", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("abort_no_request", req_cnt, r0);
        chk("abort_no_wb_valid", wbv_cnt, w0);
        chk("abort_no_done", done_cnt, d0);
        send_op(3'b010, 12'hC02, 32'd0, 5'd0, 5'd5);
        wait_wb(lat);
        chk_wb("post_abort", lat, 2, 32'h300, 5'd5, 1'b1, 1'b0);
        finish_wb("post_abort");

        // Back-to-back: in_valid held high across three instructions
        base = got_q.size();
        h0 = hs_cnt;
        d0 = done_cnt;
        exp_q.push_back({5'd5, 32'h200});
        exp_q.push_back({5'd6, 32'h200});
        exp_q.push_back({5'd7, 32'h201});
        wb_ready   = 1'b1;
        k          = 0;
        in_valid   = 1'b1;
        in_funct3  = 3'b010; in_csr = 12'hC01; in_rs1_val = 32'd0; in_uimm = 5'd0; in_rd = 5'd5;
        for (int t = 0; t < 60 && k < 3; t++) begin
            acc = in_ready;
            @(negedge clk);
            if (acc) begin
                k++;
                if (k == 1) begin
                    in_funct3 = 3'b110; in_uimm = 5'd1; in_rd = 5'd6;
                end else if (k == 2) begin
                    in_funct3 = 3'b010; in_uimm = 5'd0; in_rd = 5'd7;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_all_accepted", k, 3);
        for (int t = 0; t < 20 && hs_cnt < h0 + 3; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        wb_ready = 1'b0;
        chk("b2b_handshakes", hs_cnt, h0 + 3);
        chk("b2b_done_pulses", done_cnt, d0 + 3);
        for (int i = 0; i < 3; i++) begin
            g = (got_q.size() > base + i) ? got_q[base + i] : '1;
            e = exp_q.pop_front();
            chk("b2b_order_rd", {27'd0, g[36:32]}, {27'd0, e[36:32]});
            chk("b2b_order_data", g[31:0], e[31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
